// File: rtl/axi_lite_reg_slave_pkg.sv
// Shared types, response codes and address-decode helpers for the AXI4-Lite register slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_ADDR,
    WR_HAVE_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  // Addresses are widened to 32 bits so BASE + 4*N cannot wrap inside a narrow bus.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] nregs);
    return (addr >= base) && (addr < base + (nregs << 2));
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr,
                                           input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle; the slave modport is the register block's view.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// NUM_REGS x DATA_WIDTH register storage: byte-enabled write port, async reset,
// combinational read mux.
module axi_lite_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int IDX_W      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               widx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic [IDX_W-1:0]               ridx_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] r_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (we_i && (widx_i == IDX_W'(gi))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_i[b]) begin
              r_q[b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
          end
        end
      end

      assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end
  endgenerate

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx_i == IDX_W'(i)) begin
        rdata_o = regs_o[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit registers at BASE_ADDR, with
// independent write (AW/W/B) and read (AR/R) state machines.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REGS   = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  axi_lite_if.slave                      s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int          IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int          STRB_W  = DATA_WIDTH / 8;
  localparam logic [31:0] BASE32  = 32'(BASE_ADDR);
  localparam logic [31:0] NREGS32 = 32'(NUM_REGS);

  wr_state_t               wr_state_q, wr_state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [NUM_REGS-1:0]     pulse_q, pulse_d;

  rd_state_t               rd_state_q, rd_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic                    wr_hit, rd_hit;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   bank_rdata;

  assign aw_hs = s_axi.awvalid && awready_q;
  assign w_hs  = s_axi.wvalid  && wready_q;
  assign ar_hs = s_axi.arvalid && arready_q;

  // Whichever half arrived earlier comes from the holding register; the other is live.
  assign wr_addr = (wr_state_q == WR_HAVE_ADDR) ? awaddr_q : s_axi.awaddr;
  assign wr_data = (wr_state_q == WR_HAVE_DATA) ? wdata_q  : s_axi.wdata;
  assign wr_strb = (wr_state_q == WR_HAVE_DATA) ? wstrb_q  : s_axi.wstrb;

  assign wr_hit = addr_hit(32'(wr_addr), BASE32, NREGS32);
  assign wr_idx = IDX_W'(addr_idx(32'(wr_addr), BASE32));
  assign rd_hit = addr_hit(32'(s_axi.araddr), BASE32, NREGS32);
  assign rd_idx = IDX_W'(addr_idx(32'(s_axi.araddr), BASE32));

  assign commit = (wr_state_q != WR_RESP) && (wr_state_d == WR_RESP);

  axi_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .we_i    (commit && wr_hit),
    .widx_i  (wr_idx),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .ridx_i  (rd_idx),
    .rdata_o (bank_rdata),
    .regs_o  (reg_q)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      pulse_q    <= '0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      pulse_q    <= pulse_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs)  wr_state_d = WR_RESP;
        else if (aw_hs)     wr_state_d = WR_HAVE_ADDR;
        else if (w_hs)      wr_state_d = WR_HAVE_DATA;
      end
      WR_HAVE_ADDR: if (w_hs)           wr_state_d = WR_RESP;
      WR_HAVE_DATA: if (aw_hs)          wr_state_d = WR_RESP;
      WR_RESP:      if (s_axi.bready)   wr_state_d = WR_IDLE;
      default:                          wr_state_d = WR_IDLE;
    endcase

    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (ar_hs)        rd_state_d = RD_RESP;
      RD_RESP: if (s_axi.rready) rd_state_d = RD_IDLE;
      default:                   rd_state_d = RD_IDLE;
    endcase
  end

  // Readies and valids are registered copies of what the next state will want.
  always_comb begin
    awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_DATA);
    wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_ADDR);
    bvalid_d  = (wr_state_d == WR_RESP);
    awaddr_d  = aw_hs ? s_axi.awaddr : awaddr_q;
    wdata_d   = w_hs  ? s_axi.wdata  : wdata_q;
    wstrb_d   = w_hs  ? s_axi.wstrb  : wstrb_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    if (commit) begin
      bresp_d = wr_hit ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit && (wr_idx == IDX_W'(i))) pulse_d[i] = 1'b1;
      end
    end

    arready_d = (rd_state_d == RD_IDLE);
    rvalid_d  = (rd_state_d == RD_RESP);
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      rdata_d = rd_hit ? bank_rdata : '0;
      rresp_d = rd_hit ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: write/read paths, decode miss, collision, reset.
module tb_axi_lite_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;
  int           checks = 0;
  int           passes = 0;

  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_WIDTH(3)) bus ();

  axi_lite_reg_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .RESP_WIDTH (3),
    .NUM_REGS   (4),
    .BASE_ADDR  (0)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic b_done();
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("bvalid_clr", 128'(bus.bvalid), 128'(0));
    chk("awready_back", 128'(bus.awready), 128'(1));
  endtask

  task automatic r_done();
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("rvalid_clr", 128'(bus.rvalid), 128'(0));
    chk("arready_back", 128'(bus.arready), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    tick(); tick();
    chk("rst_awready", 128'(bus.awready), 128'(0));
    chk("rst_arready", 128'(bus.arready), 128'(0));
    chk("rst_bvalid", 128'(bus.bvalid), 128'(0));
    chk("rst_regs", reg_q, 128'(0));
    rst_n = 1'b1;
    tick();
    chk("ready_rise", 128'({bus.awready, bus.wready, bus.arready}), 128'(3'b111));

    // 1: AW and W in the same cycle
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t1_bvalid", 128'(bus.bvalid), 128'(1));
    chk("t1_bresp", 128'(bus.bresp), 128'(0));
    chk("t1_reg1", 128'(reg_q[63:32]), 128'(32'hDEADBEEF));
    chk("t1_pulse", 128'(reg_wr_pulse), 128'(4'b0010));
    tick();
    chk("t1_pulse_off", 128'(reg_wr_pulse), 128'(0));
    b_done();

    // 2: W three cycles ahead of AW, partial strobe
    bus.wdata = 32'h11223344; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wready", 128'(bus.wready), 128'(0));
      chk("t2_awready", 128'(bus.awready), 128'(1));
      if (i < 2) tick();
    end
    bus.awaddr = 8'h00; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("t2_reg0", 128'(reg_q[31:0]), 128'(32'h00003344));
    chk("t2_pulse", 128'(reg_wr_pulse), 128'(4'b0001));
    chk("t2_bvalid", 128'(bus.bvalid), 128'(1));
    b_done();

    // 3: read with rready held low
    bus.araddr = 8'h04; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_rvalid", 128'(bus.rvalid), 128'(1));
      chk("t3_rdata", 128'(bus.rdata), 128'(32'hDEADBEEF));
      chk("t3_arready", 128'(bus.arready), 128'(0));
      tick();
    end
    chk("t3_rresp", 128'(bus.rresp), 128'(0));
    r_done();

    // 4: decode miss on both paths
    bus.awaddr = 8'h40; bus.awvalid = 1'b1;
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t4_bresp", 128'(bus.bresp), 128'(2));
    chk("t4_pulse", 128'(reg_wr_pulse), 128'(0));
    chk("t4_regs", reg_q, 128'h00000000_00000000_DEADBEEF_00003344);
    b_done();
    bus.araddr = 8'h40; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    chk("t4_rresp", 128'(bus.rresp), 128'(2));
    chk("t4_rdata", 128'(bus.rdata), 128'(0));
    r_done();

    // 5: read and write to reg2 on the same edge
    bus.awaddr = 8'h08; bus.awvalid = 1'b1;
    bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 8'h08; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    chk("t5_old_rdata", 128'(bus.rdata), 128'(0));
    chk("t5_reg2", 128'(reg_q[95:64]), 128'(32'hA5A5A5A5));
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    chk("t5_both_done", 128'({bus.bvalid, bus.rvalid}), 128'(0));
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    chk("t5_new_rdata", 128'(bus.rdata), 128'(32'hA5A5A5A5));
    r_done();

    // 6: reset while a write response is pending
    bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t6_bvalid", 128'(bus.bvalid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bvalid", 128'(bus.bvalid), 128'(0));
    chk("t6_rst_regs", reg_q, 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    bus.awaddr = 8'h00; bus.awvalid = 1'b1;
    bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hC; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t6_reg0", 128'(reg_q[31:0]), 128'(32'hCAFE0000));
    chk("t6_pulse", 128'(reg_wr_pulse), 128'(4'b0001));
    chk("t6_bresp", 128'(bus.bresp), 128'(0));
    b_done();

    // zero strobe still pulses but changes nothing
    bus.awaddr = 8'h08; bus.awvalid = 1'b1;
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'h0; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t7_pulse", 128'(reg_wr_pulse), 128'(4'b0100));
    chk("t7_regs", reg_q, 128'h00000000_00000000_00000000_CAFE0000);
    b_done();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
